mux_rr_sched: RTL and testbench

Round-robin scheduler that shares the 32:1, 2-bit selection mux among 32 requesters. It accepts level requests, picks a winner fairly, and drives the mux select. It captures the selected 2-bit mux output into an output register and presents it downstream with a valid/ready handshake, tagged with the source index. It sits between the requester bank and the consumer, and owns the mux `sel` lines exclusively.

---
 rtl/mux_rr_sched_if.sv | 40 ++++
 rtl/mux_rr_sched.sv | 107 ++++++++++
 tb/tb_mux_rr_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_sched_if.sv
// mux_rr_sched_if
//   Bundles the requester bank, the shared 32:1 x 2-bit mux and the
//   downstream consumer signals around the round-robin scheduler.
//
//   Handshake: a transfer on out_* completes on a rising clock edge where
//   out_valid && out_ready are both high. While out_valid is high and
//   out_ready is low, out_data and out_src are held stable. out_valid is
//   never withdrawn before the transfer completes.
//
//   Signals
//     req       requester bank -> scheduler  level request, bit i = mux input i
//     sel       scheduler -> mux             registered mux select
//     mux_out   mux -> scheduler             combinational mux data
//     ack       scheduler -> requesters      one-hot, one-cycle capture pulse
//     out_valid scheduler -> consumer        output register holds a transfer
//     out_data  scheduler -> consumer        captured mux data
//     out_src   scheduler -> consumer        requester index of out_data
//     out_ready consumer -> scheduler        consumer can accept
//     busy      scheduler -> observer        scheduler is not idle
interface mux_rr_sched_if;
    logic [31:0] req;
    logic [4:0]  sel;
    logic [1:0]  mux_out;
    logic [31:0] ack;
    logic        out_valid;
    logic [1:0]  out_data;
    logic [4:0]  out_src;
    logic        out_ready;
    logic        busy;

    modport master (
        input  req, mux_out, out_ready,
        output sel, ack, out_valid, out_data, out_src, busy
    );

    modport slave (
        output req, mux_out, out_ready,
        input  sel, ack, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/mux_rr_sched.sv
// mux_rr_sched
//   Round-robin scheduler sharing one 32:1 x 2-bit mux among 32 requesters.
//   IDLE arbitrates and loads sel, CAPTURE registers the mux output and
//   pulses ack, OUT presents the result until the consumer takes it.
//
//   Ports
//     CLK        clock, rising edge
//     RST_N      synchronous active-low reset
//     bus        mux_rr_sched_if.master (see interface for signal list)
//     dbg_state  current FSM state (IDLE=0, CAPTURE=1, OUT=2)
//     dbg_ptr    round-robin priority pointer
module mux_rr_sched #(
    parameter int NREQ = 32,
    parameter int SELW = 5
) (
    input  logic                CLK,
    input  logic                RST_N,
    mux_rr_sched_if.master      bus,
    output logic [1:0]          dbg_state,
    output logic [SELW-1:0]     dbg_ptr
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_OUT     = 2'd2;

    logic [1:0]      state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] sel_q;
    logic [NREQ-1:0] ack_q;
    logic            out_valid_q;
    logic [1:0]      out_data_q;
    logic [SELW-1:0] out_src_q;

    // Rotate the request vector so bit 0 is the index named by ptr; the
    // lowest set bit of the rotated vector is then the winner's offset.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [SELW-1:0]   win_off;
    logic [SELW-1:0]   winner;

    always_comb begin
        req_dbl = {bus.req, bus.req} >> ptr;
        req_rot = req_dbl[NREQ-1:0];
        win_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = SELW'(i);
            end
        end
        // Natural 5-bit wrap brings the offset back into index space.
        winner = ptr + win_off;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            sel_q       <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_q <= '0;
                    if (|bus.req) begin
                        sel_q <= winner;
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // sel_q has been stable for a full cycle, so mux_out is
                    // settled. Capture unconditionally: a retracted request
                    // still completes its transfer.
                    out_data_q  <= bus.mux_out;
                    out_src_q   <= sel_q;
                    out_valid_q <= 1'b1;
                    ack_q       <= NREQ'(1) << sel_q;
                    ptr         <= sel_q + SELW'(1);
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    ack_q <= '0;
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.ack       = ack_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = (state != ST_IDLE);
    assign dbg_state     = state;
    assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched
//   Directed bench for mux_rr_sched: a vector table for reset, single
//   request and reset-mid-transfer, plus hand-written sequences for
//   fairness, wrap/skip, backpressure and idle hold.
module tb_mux_rr_sched;

    logic       CLK;
    logic       RST_N;
    logic [1:0] dbg_state;
    logic [4:0] dbg_ptr;
    logic [1:0] mux_in [32];

    int checks;
    int failures;

    mux_rr_sched_if bus ();

    mux_rr_sched dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // Behavioural model of the shared mux.
    assign bus.mux_out = mux_in[bus.sel];

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst_n;
        logic [31:0] req;
        logic        rdy;
        logic [4:0]  e_sel;
        logic        e_valid;
        logic [1:0]  e_data;
        logic [4:0]  e_src;
        logic [31:0] e_ack;
        logic        e_busy;
        logic [4:0]  e_ptr;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_default_mux();
        for (int i = 0; i < 32; i++) mux_in[i] = 2'(i);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b1;
        step();
        RST_N = 1'b1;
    endtask

    // One full transfer with out_ready high; req must already be applied.
    task automatic serve(input int idx, input string tag);
        logic [4:0]  i5;
        logic [31:0] one_hot;
        i5 = 5'(idx);
        one_hot = 32'd1 << idx;
        step();
        chk($sformatf("%s_sel_%0d", tag, idx), 32'(bus.sel), 32'(i5));
        chk($sformatf("%s_busy_%0d", tag, idx), 32'(bus.busy), 32'd1);
        step();
        chk($sformatf("%s_valid_%0d", tag, idx), 32'(bus.out_valid), 32'd1);
        chk($sformatf("%s_src_%0d", tag, idx), 32'(bus.out_src), 32'(i5));
        chk($sformatf("%s_data_%0d", tag, idx), 32'(bus.out_data), 32'(mux_in[idx]));
        chk($sformatf("%s_ack_%0d", tag, idx), bus.ack, one_hot);
        chk($sformatf("%s_ptr_%0d", tag, idx), 32'(dbg_ptr), 32'(5'(i5 + 5'd1)));
        step();
        chk($sformatf("%s_done_valid_%0d", tag, idx), 32'(bus.out_valid), 32'd0);
        chk($sformatf("%s_done_ack_%0d", tag, idx), bus.ack, 32'd0);
        chk($sformatf("%s_done_busy_%0d", tag, idx), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST_N = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b1;
        set_default_mux();
        mux_in[3] = 2'b10;

        //             rst   req            rdy  sel   vld  data   src   ack           busy ptr
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 32'h0000_0000, 1'b0, 5'd0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 1'b1, 5'd3, 1'b0, 2'd0, 5'd0, 32'h0000_0000, 1'b1, 5'd0};
        vecs[2]  = '{1'b1, 32'h0000_0008, 1'b1, 5'd3, 1'b1, 2'd2, 5'd3, 32'h0000_0008, 1'b1, 5'd4};
        vecs[3]  = '{1'b1, 32'h0000_0000, 1'b1, 5'd3, 1'b0, 2'd2, 5'd3, 32'h0000_0000, 1'b0, 5'd4};
        vecs[4]  = '{1'b1, 32'h0000_0000, 1'b1, 5'd3, 1'b0, 2'd2, 5'd3, 32'h0000_0000, 1'b0, 5'd4};
        vecs[5]  = '{1'b1, 32'h0000_0002, 1'b0, 5'd1, 1'b0, 2'd2, 5'd3, 32'h0000_0000, 1'b1, 5'd4};
        vecs[6]  = '{1'b1, 32'h0000_0002, 1'b0, 5'd1, 1'b1, 2'd1, 5'd1, 32'h0000_0002, 1'b1, 5'd2};
        vecs[7]  = '{1'b1, 32'h0000_0002, 1'b0, 5'd1, 1'b1, 2'd1, 5'd1, 32'h0000_0000, 1'b1, 5'd2};
        vecs[8]  = '{1'b0, 32'h0000_0002, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 32'h0000_0000, 1'b0, 5'd0};
        vecs[9]  = '{1'b1, 32'h0000_0002, 1'b0, 5'd1, 1'b0, 2'd0, 5'd0, 32'h0000_0000, 1'b1, 5'd0};
        vecs[10] = '{1'b1, 32'h0000_0002, 1'b1, 5'd1, 1'b1, 2'd1, 5'd1, 32'h0000_0002, 1'b1, 5'd2};
        vecs[11] = '{1'b1, 32'h0000_0000, 1'b1, 5'd1, 1'b0, 2'd1, 5'd1, 32'h0000_0000, 1'b0, 5'd2};

        // Table: reset, single request, reset in OUT, re-grant after release.
        for (int v = 0; v < 12; v++) begin
            RST_N = vecs[v].rst_n;
            bus.req = vecs[v].req;
            bus.out_ready = vecs[v].rdy;
            step();
            chk($sformatf("vec%0d_sel", v),   32'(bus.sel),       32'(vecs[v].e_sel));
            chk($sformatf("vec%0d_valid", v), 32'(bus.out_valid), 32'(vecs[v].e_valid));
            chk($sformatf("vec%0d_data", v),  32'(bus.out_data),  32'(vecs[v].e_data));
            chk($sformatf("vec%0d_src", v),   32'(bus.out_src),   32'(vecs[v].e_src));
            chk($sformatf("vec%0d_ack", v),   bus.ack,            vecs[v].e_ack);
            chk($sformatf("vec%0d_busy", v),  32'(bus.busy),      32'(vecs[v].e_busy));
            chk($sformatf("vec%0d_ptr", v),   32'(dbg_ptr),       32'(vecs[v].e_ptr));
        end

        // Full fairness: grants 0..31 then 0 again, one every 3 cycles.
        set_default_mux();
        do_reset();
        bus.req = 32'hFFFF_FFFF;
        for (int k = 0; k <= 32; k++) begin
            serve(k % 32, "fair");
        end

        // Wrap and skip.
        do_reset();
        bus.req = 32'h4000_0000;
        serve(30, "wrap");
        bus.req = 32'h4000_0001;
        serve(0, "skip");
        bus.req = 32'h8000_0000;
        serve(31, "wrap31");
        chk("wrap_ptr_zero", 32'(dbg_ptr), 32'd0);

        // Backpressure: 5 stalled cycles with req toggling underneath.
        do_reset();
        bus.req = 32'h0000_0010;
        bus.out_ready = 1'b0;
        step();
        chk("bp_sel", 32'(bus.sel), 32'd4);
        step();
        chk("bp_valid_rise", 32'(bus.out_valid), 32'd1);
        chk("bp_ack_pulse", bus.ack, 32'h0000_0010);
        for (int c = 0; c < 5; c++) begin
            bus.req = $urandom_range(0, 32'hFFFF_FFFF);
            step();
            chk($sformatf("bp_hold_valid_%0d", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_hold_data_%0d", c),  32'(bus.out_data),  32'd0);
            chk($sformatf("bp_hold_src_%0d", c),   32'(bus.out_src),   32'd4);
            chk($sformatf("bp_hold_sel_%0d", c),   32'(bus.sel),       32'd4);
            chk($sformatf("bp_hold_ack_%0d", c),   bus.ack,            32'd0);
            chk($sformatf("bp_hold_busy_%0d", c),  32'(bus.busy),      32'd1);
        end
        bus.req = 32'h0000_0020;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_busy", 32'(bus.busy), 32'd0);
        chk("bp_release_sel", 32'(bus.sel), 32'd4);
        step();
        chk("bp_next_sel", 32'(bus.sel), 32'd5);
        chk("bp_next_busy", 32'(bus.busy), 32'd1);
        step();
        chk("bp_next_src", 32'(bus.out_src), 32'd5);
        chk("bp_next_ack", bus.ack, 32'h0000_0020);
        bus.req = '0;
        step();
        chk("bp_next_done", 32'(bus.out_valid), 32'd0);

        // Idle hold: sel keeps the last winner, nothing else moves.
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("idle_busy_%0d", c),  32'(bus.busy),      32'd0);
            chk($sformatf("idle_sel_%0d", c),   32'(bus.sel),       32'd5);
            chk($sformatf("idle_ack_%0d", c),   bus.ack,            32'd0);
            chk($sformatf("idle_valid_%0d", c), 32'(bus.out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
